// File: rtl/gpio_pkg.sv
// Shared constants, types and helpers for the gpio_bank pad group.
package gpio_pkg;

  localparam int GPIO_MAX_WIDTH = 32;
  localparam int GPIO_MIN_SYNC  = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_t;

  // Width of a counter holding values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpio_in_cell.sv
// One input channel: synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge detect.
module gpio_in_cell
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic in_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   in_w;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Counter runs only while the synced value disagrees; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (synced != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = synced;
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign in_w = deb_q;
`else
  assign in_w = synced;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= in_w;
  end

  assign in_o   = in_w;
  assign rise_o = in_w & ~prev_q;
  assign fall_o = ~in_w & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Bank of WIDTH bidirectional pads with registered drive, synchronised inputs,
// edge detection and sticky maskable interrupts. Optional debounce: GPIO_DEBOUNCE_EN.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] pad,
  input  logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] out_en,
  output logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] edge_rise,
  output logic [WIDTH-1:0] edge_fall,
  input  logic [WIDTH-1:0] irq_rise_en,
  input  logic [WIDTH-1:0] irq_fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > GPIO_MAX_WIDTH || SYNC_STAGES < GPIO_MIN_SYNC ||
      DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("gpio_bank: illegal parameter set");
  end

  localparam int AW = cnt_width(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] out_q, oe_q;
  logic [WIDTH-1:0] rise_raw, fall_raw;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             irq_q, irq_d;
  logic [AW-1:0]    arm_q, arm_d;
  logic             armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      out_q <= out_data;
      oe_q  <= out_en;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    assign pad[i] = oe_q[i] ? out_q[i] : 1'bz;

    gpio_in_cell #(
      .SYNC_STAGES    (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad_i  (pad[i]),
      .in_o   (in_data[i]),
      .rise_o (rise_raw[i]),
      .fall_o (fall_raw[i])
    );
  end

  // Edges stay suppressed until the sync chain has flushed its reset zeros.
  assign armed = (arm_q == ARM_DONE);
  assign arm_d = armed ? arm_q : arm_q + 1'b1;

  assign edge_rise = rise_raw & {WIDTH{armed}};
  assign edge_fall = fall_raw & {WIDTH{armed}};

  assign pend_d = (pend_q & ~irq_clr) | (edge_rise & irq_rise_en) | (edge_fall & irq_fall_en);
  assign irq_d  = |(pend_d & irq_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q  <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      arm_q  <= arm_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_pending = pend_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: reset, drive/readback latency, arming, irq set/clear/mask.
module tb_gpio_bank;
  import gpio_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  wire  [W-1:0] pad;
  logic [W-1:0] out_data, out_en, irq_rise_en, irq_fall_en, irq_mask, irq_clr;
  logic [W-1:0] in_data, edge_rise, edge_fall, irq_pending;
  logic         irq;
  logic [W-1:0] tb_en, tb_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External pad model: optional bench driver plus a weak pull to 0 when floating.
  for (genvar i = 0; i < W; i++) begin : g_pad
    assign pad[i] = tb_en[i] ? tb_val[i] : 1'bz;
    pulldown (pad[i]);
  end

  gpio_bank #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad         (pad),
    .out_data    (out_data),
    .out_en      (out_en),
    .in_data     (in_data),
    .edge_rise   (edge_rise),
    .edge_fall   (edge_fall),
    .irq_rise_en (irq_rise_en),
    .irq_fall_en (irq_fall_en),
    .irq_mask    (irq_mask),
    .irq_clr     (irq_clr),
    .irq_pending (irq_pending),
    .irq         (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_edge(input string tag, input int ch, input edge_t exp);
    logic [1:0] e;
    e = (exp == EDGE_RISE) ? 2'b10 : (exp == EDGE_FALL) ? 2'b01 : 2'b00;
    chk(tag, {30'd0, edge_rise[ch], edge_fall[ch]}, {30'd0, e});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    out_data = 8'hA5; out_en = 8'hFF;
    irq_rise_en = '0; irq_fall_en = '0; irq_mask = '0; irq_clr = '0;
    tb_en = '0; tb_val = '0;

    // Drive requested during reset must not reach the pads.
    tick(2);
    chk("rst_pad_z", pad, 8'h00);
    chk("rst_in", in_data, 8'h00);
    chk("rst_pend", irq_pending, 8'h00);
    chk("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    tick(); chk("drv_lat1", pad, 8'hA5);
    tick(); chk("rb_lat2", in_data, 8'h00);
    tick(); chk("rb_lat3", in_data, 8'hA5);
    chk("rb_rise_armed", edge_rise, 8'hA5);
    tick(); chk("rise_1clk", edge_rise, 8'h00);

    // Pad high through reset: the rise at wake-up is swallowed by arming.
    rst_n = 1'b0; out_en = '0;
    tb_en = 8'h08; tb_val = 8'h08;
    irq_rise_en = 8'hFF; irq_mask = 8'hFF;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("arm_in", in_data, 8'h08);
    chk("arm_no_rise", edge_rise, 8'h00);
    tick(3);
    chk("arm_pend", irq_pending, 8'h00);
    chk("arm_irq", irq, 1'b0);

    // Rising edge on pad[0] -> pulse at +2, pending and irq the clk after.
    irq_rise_en = 8'h01; irq_mask = 8'h01;
    tb_en = 8'hFF; tb_val = 8'h09;
    tick(2);
    chk_edge("r0_pulse", 0, EDGE_RISE);
    chk("r0_pend_early", irq_pending, 8'h00);
    tick();
    chk("r0_pend", irq_pending, 8'h01);
    chk("r0_irq", irq, 1'b1);
    chk("r0_pulse_end", edge_rise, 8'h00);

    // Set pending[1] by a rise, then fall coincident with clear: set wins.
    tb_val = 8'h0B; irq_rise_en = 8'h02; irq_fall_en = 8'h02; irq_mask = 8'h02; irq_clr = 8'h01;
    tick(); irq_clr = '0;
    tick(); chk("r1_pulse", edge_rise, 8'h02);
    tick(); chk("r1_pend", irq_pending, 8'h02);
    chk("r1_irq", irq, 1'b1);
    tb_val = 8'h09;
    tick(2); chk_edge("f1_pulse", 1, EDGE_FALL);
    irq_clr = 8'h02;
    tick(); chk("set_wins", irq_pending, 8'h02);
    chk("set_wins_irq", irq, 1'b1);
    tick(); chk("clr_pend", irq_pending, 8'h00);
    chk("clr_irq", irq, 1'b0);
    irq_clr = '0;

    // Readback of driven pads and mask behaviour.
    tb_val = 8'h00;
    tick(4);
    irq_rise_en = 8'h0F; irq_fall_en = '0;
    tb_en = '0; out_en = 8'h0F; out_data = 8'h0F;
    tick(); chk("drv_pad", pad, 8'h0F);
    tick(); chk("drv_rb_early", in_data, 8'h00);
    tick(); chk("drv_rb", in_data, 8'h0F);
    chk("drv_rise", edge_rise, 8'h0F);
    tick(); chk("pend_0f", irq_pending, 8'h0F);
    chk("irq_m2", irq, 1'b1);
    irq_mask = 8'h00;
    tick(); chk("mask_off_irq", irq, 1'b0);
    chk("mask_keeps_pend", irq_pending, 8'h0F);
    irq_mask = 8'h08;
    tick(); chk("mask_on_irq", irq, 1'b1);

    // Asynchronous reset mid-drive.
    #1; rst_n = 1'b0;
    #1;
    chk("arst_pad_z", pad, 8'h00);
    chk("arst_pend", irq_pending, 8'h00);
    chk("arst_irq", irq, 1'b0);
    chk("arst_in", in_data, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
    out_en = '0; irq_rise_en = '0; irq_mask = '0;
    tb_en = 8'hFF; tb_val = 8'h00;
    tick();
    rst_n = 1'b1;
    tick(6);
    // Short glitch is filtered.
    tb_val = 8'h04;
    tick(3);
    tb_val = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_in", in_data, 8'h00);
      chk("glitch_edge", edge_rise, 8'h00);
    end
    // Long pulse passes: high over edges SS+DB .. SS+DB+5.
    tb_val = 8'h04;
    for (int i = 1; i <= 14; i++) begin
      if (i == 7) tb_val = 8'h00;
      tick();
      chk("deb_pulse", {31'd0, in_data[2]}, {31'd0, (i >= SS + DB && i <= SS + DB + 5)});
      if (i == SS + DB) chk_edge("deb_rise", 2, EDGE_RISE);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
